// File: rtl/uart_mmio_pkg.sv
// Shared definitions for the UART MMIO controller: register offsets, CON bit map, FSM encodings.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package uart_mmio_pkg;

    // Register offsets relative to the controller base address.
    localparam logic [31:0] TXD_OFS = 32'h0000_0000;
    localparam logic [31:0] RXD_OFS = 32'h0000_0004;
    localparam logic [31:0] CON_OFS = 32'h0000_0008;

    // CON register bit positions.
    localparam int CON_TX_INT_EN = 0;
    localparam int CON_RX_INT_EN = 1;
    localparam int CON_RX_READY  = 2;
    localparam int CON_TX_BUSY   = 3;
    localparam int CON_RX_OVF    = 4;
    localparam int CON_TX_DONE   = 5;
    localparam int CON_SEND_EN   = 6;
    localparam int CON_RECV_EN   = 7;

    // Default low-time of the active-low trigger pulses, in sysclk cycles.
    localparam int PULSE_CYC_DEF = 2;

    typedef enum logic [1:0] {
        TX_IDLE      = 2'd0,
        TX_PULSE     = 2'd1,
        TX_WAIT_BUSY = 2'd2,
        TX_WAIT_DONE = 2'd3
    } tx_state_t;

    typedef enum logic {
        RX_IDLE  = 1'b0,
        RX_CLEAR = 1'b1
    } rx_state_t;

endpackage

// File: rtl/uart_rx_fifo.sv
// Small synchronous FIFO holding received UART bytes.
// Latency: push visible at head one cycle after the push edge; head is combinational from state.
// Backpressure: none upstream; a push into a full FIFO without a same-cycle pop is dropped.
//
// Ports: clk/rst (async active-high), push_vld/push_dat, pop_vld, head_dat (current head,
// meaningless when empty), full, empty, count (log2(DEPTH)+1 bits). DEPTH must be a power of two >= 2.
module uart_rx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_vld,
    input  logic [WIDTH-1:0]       push_dat,
    input  logic                   pop_vld,
    output logic [WIDTH-1:0]       head_dat,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign empty    = (count_q == '0);
    assign full     = (count_q == FULL_CNT);
    assign count    = count_q;
    assign head_dat = mem_q[rd_ptr_q];

    // A pop on an empty FIFO does nothing, so an empty FIFO seeing push+pop just takes the push.
    // A full FIFO accepts a push only when a real pop frees the head slot in the same cycle.
    assign do_pop  = pop_vld & ~empty;
    assign do_push = push_vld & (~full | do_pop);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_dat;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/uart_mmio_ctrl.sv
// Memory-mapped UART controller: TXD/RXD/CON registers, RX byte FIFO, TX trigger sequencing, irq.
// Latency: reads are combinational; irq lags its flags by one cycle; recv/send states see 2-flop sync delay.
// Backpressure: TXD writes while a transmission is in flight are ignored; RX bytes beyond FIFO depth are dropped and flagged.
//
// Ports: sysclk, reset (async active-high); CPU side addr/MemRead/MemWrite/wdata/rdata/irq;
// UART side uart_readdata/uart_recv_state/uart_send_state in, uart_writedata/uart_send_trigger/
// uart_state_trigger (both active-low pulses) and send_enable/recv_enable (CON[6]/CON[7]) out.
module uart_mmio_ctrl
    import uart_mmio_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h4000_0018,
    parameter int          FIFO_DEPTH = 4,
    parameter int          PULSE_CYC  = PULSE_CYC_DEF
) (
    input  logic        sysclk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq,
    input  logic [7:0]  uart_readdata,
    input  logic        uart_recv_state,
    input  logic        uart_send_state,
    output logic [7:0]  uart_writedata,
    output logic        uart_send_trigger,
    output logic        uart_state_trigger,
    output logic        send_enable,
    output logic        recv_enable
);

    localparam int         CW         = $clog2(FIFO_DEPTH) + 1;
    localparam logic [7:0] PULSE_LAST = 8'(PULSE_CYC - 1);

    // Synchronizers and receive edge detector.
    logic recv_s1_q, recv_s1_d, recv_s2_q, recv_s2_d, recv_prev_q, recv_prev_d;
    logic send_s1_q, send_s1_d, send_s2_q, send_s2_d;

    tx_state_t  tx_state_q, tx_state_d;
    rx_state_t  rx_state_q, rx_state_d;
    logic [7:0] tx_cnt_q, tx_cnt_d;
    logic [7:0] rx_cnt_q, rx_cnt_d;
    logic [7:0] writedata_q, writedata_d;

    logic tx_int_en_q, tx_int_en_d, rx_int_en_q, rx_int_en_d;
    logic send_en_q, send_en_d, recv_en_q, recv_en_d;
    logic rx_ovf_q, rx_ovf_d, tx_done_q, tx_done_d;
    logic irq_q, irq_d;

    logic          sel_txd, sel_rxd, sel_con;
    logic          wr_txd, wr_con, rd_rxd;
    logic          recv_edge, rx_push, rx_ovf_set, tx_done_set;
    logic          tx_busy, rx_ready;
    logic [7:0]    fifo_head;
    logic          fifo_full, fifo_empty;
    logic [CW-1:0] fifo_count;
    logic [31:0]   con_rd;
    logic          wdata_unused;

    // Only the low byte of a write carries register content.
    assign wdata_unused = ^wdata[31:8];

    assign sel_txd = (addr == BASE_ADDR + TXD_OFS);
    assign sel_rxd = (addr == BASE_ADDR + RXD_OFS);
    assign sel_con = (addr == BASE_ADDR + CON_OFS);
    assign wr_txd  = MemWrite & sel_txd;
    assign wr_con  = MemWrite & sel_con;
    assign rd_rxd  = MemRead & sel_rxd;

    assign recv_edge = recv_s2_q & ~recv_prev_q;
    assign tx_busy   = (tx_state_q != TX_IDLE);
    assign rx_ready  = (fifo_count != '0);
    // Drop and flag only when no pop makes room this cycle.
    assign rx_ovf_set = rx_push & fifo_full & ~rd_rxd;

    uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_rx_fifo (
        .clk      (sysclk),
        .rst      (reset),
        .push_vld (rx_push),
        .push_dat (uart_readdata),
        .pop_vld  (rd_rxd),
        .head_dat (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    always_comb begin
        recv_s1_d   = uart_recv_state;
        recv_s2_d   = recv_s1_q;
        recv_prev_d = recv_s2_q;
        send_s1_d   = uart_send_state;
        send_s2_d   = send_s1_q;
    end

    // TX sequencing: latch byte, pulse trigger low, then follow send_state 1->0->1.
    always_comb begin
        tx_state_d        = tx_state_q;
        tx_cnt_d          = tx_cnt_q;
        writedata_d       = writedata_q;
        tx_done_set       = 1'b0;
        uart_send_trigger = 1'b1;
        case (tx_state_q)
            TX_IDLE: begin
                if (wr_txd) begin
                    writedata_d = wdata[7:0];
                    tx_cnt_d    = '0;
                    tx_state_d  = TX_PULSE;
                end
            end
            TX_PULSE: begin
                uart_send_trigger = 1'b0;
                if (tx_cnt_q == PULSE_LAST) begin
                    tx_state_d = TX_WAIT_BUSY;
                end else begin
                    tx_cnt_d = tx_cnt_q + 8'd1;
                end
            end
            TX_WAIT_BUSY: begin
                if (!send_s2_q) begin
                    tx_state_d = TX_WAIT_DONE;
                end
            end
            TX_WAIT_DONE: begin
                if (send_s2_q) begin
                    tx_done_set = 1'b1;
                    tx_state_d  = TX_IDLE;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    // RX sequencing: capture on the synced rising edge, then pulse state_trigger low to clear it.
    always_comb begin
        rx_state_d         = rx_state_q;
        rx_cnt_d           = rx_cnt_q;
        rx_push            = 1'b0;
        uart_state_trigger = 1'b1;
        case (rx_state_q)
            RX_IDLE: begin
                if (recv_edge) begin
                    rx_push    = 1'b1;
                    rx_cnt_d   = '0;
                    rx_state_d = RX_CLEAR;
                end
            end
            RX_CLEAR: begin
                uart_state_trigger = 1'b0;
                if (rx_cnt_q == PULSE_LAST) begin
                    rx_state_d = RX_IDLE;
                end else begin
                    rx_cnt_d = rx_cnt_q + 8'd1;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // CON register: hardware set of a sticky flag wins over a same-cycle write-1-clear.
    always_comb begin
        tx_int_en_d = tx_int_en_q;
        rx_int_en_d = rx_int_en_q;
        send_en_d   = send_en_q;
        recv_en_d   = recv_en_q;
        rx_ovf_d    = rx_ovf_q;
        tx_done_d   = tx_done_q;
        if (wr_con) begin
            tx_int_en_d = wdata[CON_TX_INT_EN];
            rx_int_en_d = wdata[CON_RX_INT_EN];
            send_en_d   = wdata[CON_SEND_EN];
            recv_en_d   = wdata[CON_RECV_EN];
            rx_ovf_d    = rx_ovf_q & ~wdata[CON_RX_OVF];
            tx_done_d   = tx_done_q & ~wdata[CON_TX_DONE];
        end
        if (rx_ovf_set) begin
            rx_ovf_d = 1'b1;
        end
        if (tx_done_set) begin
            tx_done_d = 1'b1;
        end
        irq_d = (tx_int_en_q & tx_done_q) | (rx_int_en_q & rx_ready);
    end

    always_comb begin
        con_rd                = '0;
        con_rd[CON_TX_INT_EN] = tx_int_en_q;
        con_rd[CON_RX_INT_EN] = rx_int_en_q;
        con_rd[CON_RX_READY]  = rx_ready;
        con_rd[CON_TX_BUSY]   = tx_busy;
        con_rd[CON_RX_OVF]    = rx_ovf_q;
        con_rd[CON_TX_DONE]   = tx_done_q;
        con_rd[CON_SEND_EN]   = send_en_q;
        con_rd[CON_RECV_EN]   = recv_en_q;
    end

    always_comb begin
        rdata = '0;
        if (sel_txd) begin
            rdata = {24'h0, writedata_q};
        end else if (sel_rxd) begin
            rdata = fifo_empty ? 32'h0 : {24'h0, fifo_head};
        end else if (sel_con) begin
            rdata = con_rd;
        end
    end

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            recv_s1_q   <= 1'b0;
            recv_s2_q   <= 1'b0;
            recv_prev_q <= 1'b0;
            send_s1_q   <= 1'b1;
            send_s2_q   <= 1'b1;
            tx_state_q  <= TX_IDLE;
            rx_state_q  <= RX_IDLE;
            tx_cnt_q    <= '0;
            rx_cnt_q    <= '0;
            writedata_q <= '0;
            tx_int_en_q <= 1'b0;
            rx_int_en_q <= 1'b0;
            send_en_q   <= 1'b0;
            recv_en_q   <= 1'b0;
            rx_ovf_q    <= 1'b0;
            tx_done_q   <= 1'b0;
            irq_q       <= 1'b0;
        end else begin
            recv_s1_q   <= recv_s1_d;
            recv_s2_q   <= recv_s2_d;
            recv_prev_q <= recv_prev_d;
            send_s1_q   <= send_s1_d;
            send_s2_q   <= send_s2_d;
            tx_state_q  <= tx_state_d;
            rx_state_q  <= rx_state_d;
            tx_cnt_q    <= tx_cnt_d;
            rx_cnt_q    <= rx_cnt_d;
            writedata_q <= writedata_d;
            tx_int_en_q <= tx_int_en_d;
            rx_int_en_q <= rx_int_en_d;
            send_en_q   <= send_en_d;
            recv_en_q   <= recv_en_d;
            rx_ovf_q    <= rx_ovf_d;
            tx_done_q   <= tx_done_d;
            irq_q       <= irq_d;
        end
    end

    assign irq            = irq_q;
    assign uart_writedata = writedata_q;
    assign send_enable    = send_en_q;
    assign recv_enable    = recv_en_q;

endmodule

// File: doc/uart_mmio_ctrl.md
Name: uart_mmio_ctrl

Overview:
- Memory-mapped UART peripheral controller between the single-cycle MIPS data bus and the UART wrapper (sender + receiver + state flags).
- Receive path: captures each received byte into a 4-deep RX FIFO, then clears the wrapper's receive flag.
- Transmit path: accepts bytes written by the CPU, sequences the active-low send trigger and tracks completion.
- Exposes TXD/RXD/CON registers and a level interrupt to the CPU.

Parameters:
- BASE_ADDR, 32'h4000_0018, byte address of TXD; RXD = BASE+4, CON = BASE+8.
- FIFO_DEPTH, 4, RX FIFO entries (power of two).
- PULSE_CYC, 2, low-time in sysclk cycles of send_trigger and Uart_state_trigger pulses.

Ports:
- sysclk  in  1  system clock, all state rising-edge.
- reset  in  1  asynchronous, active-high reset.
- addr  in  32  CPU byte address.
- MemRead  in  1  read strobe, one cycle per access.
- MemWrite  in  1  write strobe, one cycle per access.
- wdata  in  32  CPU write data.
- rdata  out  32  read data, combinational from addr/state.
- irq  out  1  level interrupt.
- uart_readdata  in  8  received byte from UART wrapper.
- uart_recv_state  in  1  1 = byte received (asynchronous to sysclk).
- uart_send_state  in  1  1 = transmitter idle/finished (asynchronous).
- uart_writedata  out  8  byte to transmit.
- uart_send_trigger  out  1  active-low start pulse.
- uart_state_trigger  out  1  active-low pulse clearing recv_state.
- send_enable  out  1  = CON[6].
- recv_enable  out  1  = CON[7].

Behaviour:
- Reset values: rdata=0, irq=0, uart_writedata=0, uart_send_trigger=1, uart_state_trigger=1, send_enable=0, recv_enable=0, FIFO empty, all CON bits 0, both FSMs in IDLE.
- Synchronizers: uart_recv_state and uart_send_state pass through 2-flop synchronizers (reset value recv=0, send=1). All decisions use synced values.
- CON bits:
  - [0] tx_int_en, RW.
  - [1] rx_int_en, RW.
  - [2] rx_ready, RO = FIFO non-empty.
  - [3] tx_busy, RO = TX FSM not IDLE.
  - [4] rx_overflow, sticky, write-1-clear.
  - [5] tx_done, sticky, write-1-clear; also set by TX completion.
  - [6] send_enable, RW.
  - [7] recv_enable, RW.
  - [31:8] read 0.
- Read decode:
  - TXD reads the last written byte zero-extended.
  - RXD reads FIFO head zero-extended, or 0 if empty.
  - Unmapped addresses read 0 and writes to them are ignored.
- RXD read with MemRead high pops one entry at that clock edge. A pop when empty is a no-op.
- TX FSM (IDLE, PULSE, WAIT_BUSY, WAIT_DONE):
  - IDLE: a write to TXD latches wdata[7:0] into uart_writedata, then go to PULSE.
  - PULSE: drive uart_send_trigger=0 for PULSE_CYC cycles, then go to WAIT_BUSY.
  - WAIT_BUSY: wait for synced send_state=0, then go to WAIT_DONE.
  - WAIT_DONE: wait for synced send_state=1, then set tx_done and go to IDLE.
  - A TXD write when not IDLE is ignored: uart_writedata is unchanged and no flag is set.
- RX FSM (IDLE, CLEAR):
  - A rising edge of synced recv_state pushes uart_readdata into the FIFO and moves to CLEAR.
  - CLEAR drives uart_state_trigger=0 for PULSE_CYC cycles, then returns to IDLE.
  - Further edges during CLEAR are impossible; they are not counted.
- FIFO boundary cases:
  - Push when full with no simultaneous pop: byte dropped, rx_overflow set.
  - Push and pop in the same cycle: both happen; a full FIFO stays full with no overflow; an empty FIFO takes the push first, then the pop is a no-op.
  - Pointers wrap modulo FIFO_DEPTH; the count is held in log2(DEPTH)+1 bits.
- CON write: RW bits load from wdata, W1C bits clear where wdata=1. If a hardware set and a W1C clear hit the same cycle, the set wins.
- irq = (tx_int_en & tx_done) | (rx_int_en & rx_ready), registered, so it has 1-cycle latency.

Decomposition:
- Shared package (uart_mmio_pkg): address offsets, CON bit indices, TX/RX state encodings, PULSE_CYC default.
- One natural sub-module: uart_rx_fifo (synchronous FIFO with push/pop/full/empty/count and simultaneous push-pop rule). The FSMs and register file stay in the top.

Test Plan:
- Reset mid-transmit: assert reset during PULSE -> uart_send_trigger=1, tx_busy=0, FIFO empty and rdata=0 immediately, with no clock needed.
- Write TXD=0x1234_5A41 with the model dropping send_state for 100 cycles -> uart_writedata=8'h41, send_trigger low for exactly 2 cycles, tx_busy=1 until send_state returns, then tx_done=1 and irq=1 one cycle later (tx_int_en=1).
- Write TXD=0x42 while busy -> uart_writedata stays 0x41 and the transmission completes normally.
- Model receives 0x55, 0xAA -> each triggers a 2-cycle low on uart_state_trigger; RXD reads return 0x55 then 0xAA, then 0 with rx_ready=0.
- Receive 5 bytes without reading -> first 4 retained in order, rx_overflow=1; writing CON with bit4=1 clears it.
- FIFO full, RXD read coincident with new-byte push -> count stays 4, no overflow, order preserved.
